// File: rtl/multi_queue_shared_buf_if.sv
// ---------------------------------------------------------------------------
// multi_queue_shared_buf_if
// Push/pop handshake bundle for multi_queue_shared_buf.
//   push_valid/push_idx/push_data : enqueue request from the producer side
//   push_ready                    : enqueue accepted when valid & ready
//   pop_valid/pop_idx             : dequeue request from the consumer side
//   pop_data/pop_ready            : head payload of pop_idx and accept flag
// Modports: master = traffic source/sink (bench, classifier side),
//           slave  = the shared-buffer queue block.
// ---------------------------------------------------------------------------
interface multi_queue_shared_buf_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 2
);
    logic                  push_valid;
    logic [IDX_WIDTH-1:0]  push_idx;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  push_ready;
    logic                  pop_valid;
    logic [IDX_WIDTH-1:0]  pop_idx;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  pop_ready;

    modport master (
        output push_valid, push_idx, push_data, pop_valid, pop_idx,
        input  push_ready, pop_data, pop_ready
    );

    modport slave (
        input  push_valid, push_idx, push_data, pop_valid, pop_idx,
        output push_ready, pop_data, pop_ready
    );
endinterface

// File: rtl/multi_queue_shared_buf.sv
// ---------------------------------------------------------------------------
// multi_queue_shared_buf
// NUM_LISTS FIFO queues sharing one NUM_ELEMS-entry payload buffer. Each
// queue is a linked list (head/tail/count) threaded through next_ptr; unused
// nodes form a free list. After reset an INIT phase chains every node into
// the free list, one node per cycle, before push/pop are accepted.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : push/pop handshake (multi_queue_shared_buf_if.slave)
//   empty    : per-queue empty flags
//   full     : every buffer entry allocated
//   count    : packed per-queue occupancy, queue i at [CNT_WIDTH*i +: CNT_WIDTH]
//   err      : sticky {underflow, overflow}
// Optional feature macro: MQ_ERR_FLAGS_EN builds the sticky error flags;
// without it err is constant 2'b00.
// ---------------------------------------------------------------------------
module multi_queue_shared_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ELEMS  = 8,
    parameter int NUM_LISTS  = 4,
    parameter int PTR_WIDTH  = $clog2(NUM_ELEMS),
    parameter int CNT_WIDTH  = PTR_WIDTH + 1,
    parameter int IDX_WIDTH  = $clog2(NUM_LISTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    multi_queue_shared_buf_if.slave        bus,
    output logic [NUM_LISTS-1:0]           empty,
    output logic                           full,
    output logic [NUM_LISTS*CNT_WIDTH-1:0] count,
    output logic [1:0]                     err
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                state_r;
    logic [PTR_WIDTH-1:0]  init_idx_r;
    logic [DATA_WIDTH-1:0] mem_r      [NUM_ELEMS];
    logic [PTR_WIDTH-1:0]  next_ptr_r [NUM_ELEMS];
    logic [PTR_WIDTH-1:0]  head_r     [NUM_LISTS];
    logic [PTR_WIDTH-1:0]  tail_r     [NUM_LISTS];
    logic [CNT_WIDTH-1:0]  count_r    [NUM_LISTS];
    logic [PTR_WIDTH-1:0]  free_head_r;
    logic [PTR_WIDTH-1:0]  free_tail_r;
    logic [CNT_WIDTH-1:0]  free_cnt_r;

    logic                  push_ready_s;
    logic                  pop_ready_s;
    logic                  push_fire_s;
    logic                  pop_fire_s;
    logic                  same_q_s;
    logic                  push_to_empty_s;
    logic [CNT_WIDTH-1:0]  free_after_take_s;
    logic [PTR_WIDTH-1:0]  pop_node_s;
    logic                  init_last_s;

    // Handshake readiness, accept strobes and list-splice decisions.
    always_comb begin
        push_ready_s = (state_r == ST_RUN) && (free_cnt_r != {CNT_WIDTH{1'b0}});
        pop_ready_s  = (state_r == ST_RUN) && (count_r[bus.pop_idx] != {CNT_WIDTH{1'b0}});
        push_fire_s  = bus.push_valid && push_ready_s;
        pop_fire_s   = bus.pop_valid && pop_ready_s;
        same_q_s     = pop_fire_s && (bus.pop_idx == bus.push_idx);
        // Target queue is empty now, or its only entry leaves this cycle.
        push_to_empty_s = (count_r[bus.push_idx] == {CNT_WIDTH{1'b0}}) ||
                          (same_q_s && (count_r[bus.push_idx] == CNT_WIDTH'(1)));
        // Free-list depth once a same-cycle push has taken its node.
        if (push_fire_s) begin
            free_after_take_s = free_cnt_r - CNT_WIDTH'(1);
        end else begin
            free_after_take_s = free_cnt_r;
        end
        pop_node_s  = head_r[bus.pop_idx];
        init_last_s = (init_idx_r == PTR_WIDTH'(NUM_ELEMS - 1));
    end

    // Status and handshake outputs.
    always_comb begin
        empty = '0;
        count = '0;
        for (int i = 0; i < NUM_LISTS; i++) begin
            empty[i] = (count_r[i] == {CNT_WIDTH{1'b0}});
            count[CNT_WIDTH*i +: CNT_WIDTH] = count_r[i];
        end
        full           = (free_cnt_r == {CNT_WIDTH{1'b0}});
        bus.push_ready = push_ready_s;
        bus.pop_ready  = pop_ready_s;
        bus.pop_data   = mem_r[pop_node_s];
    end

    // INIT/RUN state machine, linked-list and free-list maintenance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            init_idx_r  <= '0;
            free_head_r <= '0;
            free_tail_r <= PTR_WIDTH'(NUM_ELEMS - 1);
            free_cnt_r  <= CNT_WIDTH'(NUM_ELEMS);
            for (int i = 0; i < NUM_LISTS; i++) begin
                count_r[i] <= '0;
                head_r[i]  <= '0;
                tail_r[i]  <= '0;
            end
        end else begin
            case (state_r)
                ST_INIT: begin
                    // Chain node i -> i+1; the last node points back at 0.
                    next_ptr_r[init_idx_r] <= init_last_s ? '0 : init_idx_r + PTR_WIDTH'(1);
                    init_idx_r             <= init_idx_r + PTR_WIDTH'(1);
                    if (init_last_s) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Pop advances the head first; a push into an emptied
                    // queue below overrides it with the new node.
                    if (pop_fire_s) begin
                        head_r[bus.pop_idx] <= next_ptr_r[pop_node_s];
                    end
                    if (push_fire_s) begin
                        mem_r[free_head_r]   <= bus.push_data;
                        tail_r[bus.push_idx] <= free_head_r;
                        free_head_r          <= next_ptr_r[free_head_r];
                        if (push_to_empty_s) begin
                            head_r[bus.push_idx] <= free_head_r;
                        end else begin
                            next_ptr_r[tail_r[bus.push_idx]] <= free_head_r;
                        end
                    end
                    // Return the popped node to the free-list tail; this
                    // write never hits the push's tail (allocated vs free).
                    if (pop_fire_s) begin
                        free_tail_r <= pop_node_s;
                        if (free_after_take_s == {CNT_WIDTH{1'b0}}) begin
                            free_head_r <= pop_node_s;
                        end else begin
                            next_ptr_r[free_tail_r] <= pop_node_s;
                        end
                    end
                    for (int i = 0; i < NUM_LISTS; i++) begin
                        if (push_fire_s && (bus.push_idx == IDX_WIDTH'(i)) &&
                            !(pop_fire_s && (bus.pop_idx == IDX_WIDTH'(i)))) begin
                            count_r[i] <= count_r[i] + CNT_WIDTH'(1);
                        end else if (pop_fire_s && (bus.pop_idx == IDX_WIDTH'(i)) &&
                                     !(push_fire_s && (bus.push_idx == IDX_WIDTH'(i)))) begin
                            count_r[i] <= count_r[i] - CNT_WIDTH'(1);
                        end
                    end
                    if (push_fire_s && !pop_fire_s) begin
                        free_cnt_r <= free_cnt_r - CNT_WIDTH'(1);
                    end else if (pop_fire_s && !push_fire_s) begin
                        free_cnt_r <= free_cnt_r + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

`ifdef MQ_ERR_FLAGS_EN
    logic [1:0] err_r;

    // Sticky overflow/underflow flags, armed only once INIT has finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 2'b00;
        end else if (state_r == ST_RUN) begin
            if (bus.push_valid && !push_ready_s) begin
                err_r[0] <= 1'b1;
            end
            if (bus.pop_valid && !pop_ready_s) begin
                err_r[1] <= 1'b1;
            end
        end
    end

    assign err = err_r;
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_multi_queue_shared_buf.sv
// ---------------------------------------------------------------------------
// tb_multi_queue_shared_buf
// Scoreboard bench: per-queue expected-payload queues are filled when a push
// is expected to be accepted and drained/compared when a pop is accepted.
// ---------------------------------------------------------------------------
module tb_multi_queue_shared_buf;
    localparam int DW = 8;
    localparam int NE = 8;
    localparam int NL = 4;
    localparam int CW = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NL-1:0]     empty;
    logic              full;
    logic [NL*CW-1:0]  count;
    logic [1:0]        err;

    logic [DW-1:0]     sb [NL][$];
    int                checks = 0;
    int                errors = 0;
    bit                run_m;
    logic [1:0]        err_m;

    always #5 clk = ~clk;

    multi_queue_shared_buf_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

    multi_queue_shared_buf #(
        .DATA_WIDTH(DW),
        .NUM_ELEMS (NE),
        .NUM_LISTS (NL)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .empty(empty),
        .full (full),
        .count(count),
        .err  (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int total();
        int t = 0;
        for (int i = 0; i < NL; i++) t += sb[i].size();
        return t;
    endfunction

    task automatic check_status();
        for (int i = 0; i < NL; i++) begin
            check_eq($sformatf("empty[%0d]", i), 32'(empty[i]), 32'(sb[i].size() == 0));
            check_eq($sformatf("count[%0d]", i), 32'(count[CW*i +: CW]), 32'(sb[i].size()));
        end
        check_eq("full", 32'(full), 32'(total() == NE));
`ifdef MQ_ERR_FLAGS_EN
        check_eq("err", 32'(err), 32'(err_m));
`else
        check_eq("err", 32'(err), 32'h0);
`endif
    endtask

    // One clock cycle of stimulus, starting and ending at a negedge.
    task automatic step(input bit pv, input logic [IW-1:0] pi, input logic [DW-1:0] pd,
                        input bit ov, input logic [IW-1:0] oi);
        bit            epr;
        bit            eor;
        logic [DW-1:0] exp_d;
        bus.push_valid = pv;
        bus.push_idx   = pi;
        bus.push_data  = pd;
        bus.pop_valid  = ov;
        bus.pop_idx    = oi;
        #1;
        epr = run_m && (total() < NE);
        eor = run_m && (sb[oi].size() != 0);
        check_eq("push_ready", 32'(bus.push_ready), 32'(epr));
        check_eq("pop_ready", 32'(bus.pop_ready), 32'(eor));
        if (run_m && pv && !epr) err_m[0] = 1'b1;
        if (run_m && ov && !eor) err_m[1] = 1'b1;
        if (ov && eor) begin
            exp_d = sb[oi].pop_front();
            check_eq($sformatf("pop_data q%0d", oi), 32'(bus.pop_data), 32'(exp_d));
        end
        if (pv && epr) sb[pi].push_back(pd);
        @(posedge clk);
        @(negedge clk);
        bus.push_valid = 1'b0;
        bus.pop_valid  = 1'b0;
        check_status();
    endtask

    task automatic do_reset();
        bus.push_valid = 1'b0;
        bus.pop_valid  = 1'b0;
        rst   = 1'b1;
        run_m = 1'b0;
        err_m = 2'b00;
        for (int i = 0; i < NL; i++) sb[i].delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_status();
        // Ready must stay low for exactly NE cycles after reset release.
        for (int i = 0; i <= NE; i++) begin
            #1;
            check_eq($sformatf("init_ready c%0d", i), 32'(bus.push_ready), 32'(i == NE));
            if (i < NE) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        run_m = 1'b1;
    endtask

    initial begin
        bus.push_valid = 1'b0;
        bus.push_idx   = '0;
        bus.push_data  = '0;
        bus.pop_valid  = 1'b0;
        bus.pop_idx    = '0;
        rst            = 1'b1;

        do_reset();

        // FIFO order on one queue.
        step(1'b1, 2'd2, 8'h11, 1'b0, 2'd0);
        step(1'b1, 2'd2, 8'h22, 1'b0, 2'd0);
        step(1'b1, 2'd2, 8'h33, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);

        // Fill the buffer across queues 0 and 3, then overflow.
        for (int i = 0; i < NE; i++) begin
            step(1'b1, (i % 2 == 1) ? 2'd3 : 2'd0, 8'(8'h40 + i), 1'b0, 2'd0);
        end
        step(1'b1, 2'd0, 8'hFF, 1'b0, 2'd0);

        // Pop frees a node but the same-cycle push is still refused.
        step(1'b1, 2'd1, 8'hAB, 1'b1, 2'd0);
        step(1'b1, 2'd1, 8'hAB, 1'b0, 2'd0);

        // Drain queues 0, 3 and 1.
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);

        // Single-entry queue: same-cycle pop and push on it.
        step(1'b1, 2'd1, 8'h5A, 1'b0, 2'd0);
        step(1'b1, 2'd1, 8'hC3, 1'b1, 2'd1);
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
        // Underflow on the now-empty queue.
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);

        // Mixed random traffic, including push and pop on different queues.
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, NL - 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, NL - 1)));
        end

        // Reset with live traffic, then refill completely and read back.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 2'(i % NL), 8'(8'h60 + i), 1'b0, 2'd0);
        do_reset();
        for (int i = 0; i < NE; i++) step(1'b1, 2'(i % NL), 8'(8'h80 + i), 1'b0, 2'd0);
        for (int i = 0; i < NE; i++) step(1'b0, 2'd0, 8'h00, 1'b1, 2'(i % NL));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
